// File: rtl/ranging_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ranging_pkg                                                                |
// | State encoding and shared constants for the ranging sequencer.             |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package ranging_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_TRIG      = 3'd1,
    ST_WAIT_ECHO = 3'd2,
    ST_MEASURE   = 3'd3,
    ST_HOLDOFF   = 3'd4
  } state_t;

  localparam int C_SYNC_DEPTH = 2;

endpackage
`default_nettype wire

// File: rtl/phase_timer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | phase_timer                                                                |
// | Loadable down-counter; expired is high while the count sits at zero.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module phase_timer #(
  parameter int CNT_LEN = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [CNT_LEN-1:0] load_val,
  output logic               expired
);

  logic [CNT_LEN-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= load_val;
    end else if (r_count != '0) begin
      r_count <= r_count - CNT_LEN'(1);
    end
  end

  assign expired = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/ranging_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ranging_sequencer                                                          |
// | Trigger / echo-wait / echo-width / hold-off sequencer with a shared timer. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module ranging_sequencer
  import ranging_pkg::*;
#(
  parameter int CNT_LEN  = 16,
  parameter int ECHO_LEN = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                continuous,
  input  logic [CNT_LEN-1:0]  trig_len,
  input  logic [CNT_LEN-1:0]  echo_wait,
  input  logic [CNT_LEN-1:0]  holdoff,
  input  logic                echo,
  output logic                trig,
  output logic                busy,
  output logic [ECHO_LEN-1:0] result,
  output logic                result_valid,
  output logic                overrange,
  output logic                timeout_err
);

  localparam logic [ECHO_LEN-1:0] C_WIDTH_MAX = {ECHO_LEN{1'b1}};
  localparam logic [ECHO_LEN-1:0] C_WIDTH_SAT = C_WIDTH_MAX - ECHO_LEN'(1);

  state_t                  r_state;
  state_t                  w_state_next;
  logic [C_SYNC_DEPTH-1:0] r_sync;
  logic                    r_echo_d;
  logic                    w_echo_s;
  logic                    w_rise;
  logic [CNT_LEN-1:0]      r_echo_wait;
  logic [CNT_LEN-1:0]      r_holdoff;
  logic [CNT_LEN-1:0]      w_trig_m1;
  logic [CNT_LEN-1:0]      w_wait_m1;
  logic [ECHO_LEN-1:0]     r_width;
  logic                    r_trig;
  logic [ECHO_LEN-1:0]     r_result;
  logic                    r_result_valid;
  logic                    r_overrange;
  logic                    r_timeout_err;
  logic                    w_load;
  logic [CNT_LEN-1:0]      w_load_val;
  logic                    w_expired;
  logic                    w_meas_start;
  logic                    w_done;
  logic                    w_sat;
  logic                    w_timeout;

  assign w_echo_s = r_sync[C_SYNC_DEPTH-1];
  assign w_rise   = w_echo_s & ~r_echo_d;

  // A phase of length L loads L-1: the state is left on the edge after expiry.
  assign w_trig_m1 = (trig_len == '0)    ? '0 : trig_len - CNT_LEN'(1);
  assign w_wait_m1 = (r_echo_wait == '0) ? '0 : r_echo_wait - CNT_LEN'(1);

  always_comb begin
    w_state_next = r_state;
    w_meas_start = 1'b0;
    w_done       = 1'b0;
    w_sat        = 1'b0;
    w_timeout    = 1'b0;
    case (r_state)
      ST_IDLE:      if (start) w_state_next = ST_TRIG;
      ST_TRIG:      if (w_expired) w_state_next = ST_WAIT_ECHO;
      ST_WAIT_ECHO: begin
        if (w_rise) begin
          w_state_next = ST_MEASURE;
          w_meas_start = 1'b1;
        end else if (w_expired) begin
          w_state_next = ST_HOLDOFF;
          w_timeout    = 1'b1;
        end
      end
      ST_MEASURE: begin
        if (!w_echo_s) begin
          w_state_next = ST_HOLDOFF;
          w_done       = 1'b1;
        end else if (r_width >= C_WIDTH_SAT) begin
          w_state_next = ST_HOLDOFF;
          w_sat        = 1'b1;
        end
      end
      ST_HOLDOFF:   if (w_expired) w_state_next = continuous ? ST_TRIG : ST_IDLE;
      default:      w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_load     = (w_state_next != r_state);
    w_load_val = '0;
    case (w_state_next)
      ST_TRIG:      w_load_val = w_trig_m1;
      ST_WAIT_ECHO: w_load_val = w_wait_m1;
      ST_HOLDOFF:   w_load_val = r_holdoff;
      default:      w_load_val = '0;
    endcase
  end

  phase_timer #(.CNT_LEN(CNT_LEN)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (w_load),
    .load_val (w_load_val),
    .expired  (w_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= ST_IDLE;
      r_sync         <= '0;
      r_echo_d       <= 1'b0;
      r_echo_wait    <= '0;
      r_holdoff      <= '0;
      r_width        <= '0;
      r_trig         <= 1'b0;
      r_result       <= '0;
      r_result_valid <= 1'b0;
      r_overrange    <= 1'b0;
      r_timeout_err  <= 1'b0;
    end else begin
      r_state        <= w_state_next;
      r_sync         <= {r_sync[C_SYNC_DEPTH-2:0], echo};
      r_echo_d       <= w_echo_s;
      r_trig         <= (w_state_next == ST_TRIG);
      r_result_valid <= w_done | w_sat;
      r_timeout_err  <= w_timeout;
      if (w_state_next == ST_TRIG && r_state != ST_TRIG) begin
        r_echo_wait <= echo_wait;
        r_holdoff   <= holdoff;
      end
      if (w_meas_start) begin
        r_width <= ECHO_LEN'(1);
      end else if (r_state == ST_MEASURE && w_echo_s && !w_sat) begin
        r_width <= r_width + ECHO_LEN'(1);
      end
      if (w_done) begin
        r_result    <= r_width;
        r_overrange <= 1'b0;
      end else if (w_sat) begin
        r_result    <= C_WIDTH_MAX;
        r_overrange <= 1'b1;
      end
    end
  end

  assign trig         = r_trig;
  assign busy         = (r_state != ST_IDLE);
  assign result       = r_result;
  assign result_valid = r_result_valid;
  assign overrange    = r_overrange;
  assign timeout_err  = r_timeout_err;

endmodule
`default_nettype wire

// File: tb/tb_ranging_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_ranging_sequencer                                                       |
// | Directed self-checking bench for ranging_sequencer (16-bit and 8-bit echo).|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_ranging_sequencer;
  import ranging_pkg::*;

  localparam int C_BOUND = 3000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        continuous = 1'b0;
  logic [15:0] trig_len = 16'd10;
  logic [15:0] echo_wait = 16'd200;
  logic [15:0] holdoff = 16'd5;
  logic        echo = 1'b0;

  logic        trig, busy, result_valid, overrange, timeout_err;
  logic [15:0] result;
  logic        trig8, busy8, result_valid8, overrange8, timeout_err8;
  logic [7:0]  result8;

  int n_cmp = 0;
  int n_err = 0;

  ranging_sequencer #(.CNT_LEN(16), .ECHO_LEN(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .continuous(continuous),
    .trig_len(trig_len), .echo_wait(echo_wait), .holdoff(holdoff), .echo(echo),
    .trig(trig), .busy(busy), .result(result), .result_valid(result_valid),
    .overrange(overrange), .timeout_err(timeout_err)
  );

  ranging_sequencer #(.CNT_LEN(16), .ECHO_LEN(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start), .continuous(continuous),
    .trig_len(trig_len), .echo_wait(echo_wait), .holdoff(holdoff), .echo(echo),
    .trig(trig8), .busy(busy8), .result(result8), .result_valid(result_valid8),
    .overrange(overrange8), .timeout_err(timeout_err8)
  );

  always #5 clk = ~clk;

  // Event monitor on the 16-bit instance, sampled mid-cycle.
  int   cyc = 0;
  int   trig_hi = 0, rises_n = 0, falls_n = 0, rv_n = 0, to_n = 0, both_n = 0;
  int   rise_cyc = 0, fall_cyc = 0, rv_cyc = 0, to_cyc = 0;
  logic trig_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (trig) trig_hi = trig_hi + 1;
    if (trig && !trig_prev) begin rises_n = rises_n + 1; rise_cyc = cyc; end
    if (!trig && trig_prev) begin falls_n = falls_n + 1; fall_cyc = cyc; end
    if (result_valid) begin rv_n = rv_n + 1; rv_cyc = cyc; end
    if (timeout_err) begin to_n = to_n + 1; to_cyc = cyc; end
    if (result_valid && timeout_err) both_n = both_n + 1;
    trig_prev = trig;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      #1;
    end
  endtask

  function automatic int evt_count(input int which);
    case (which)
      0: return falls_n;
      1: return rises_n;
      2: return rv_n;
      default: return to_n;
    endcase
  endfunction

  // which: 0 trig fall, 1 trig rise, 2 result_valid, 3 timeout_err
  task automatic wait_evt(input int which, input string tag);
    int base;
    int seen;
    base = evt_count(which);
    seen = 0;
    for (int i = 0; i < C_BOUND && seen == 0; i++) begin
      tick();
      if (evt_count(which) != base) seen = 1;
    end
    chk(tag, seen, 1);
  endtask

  task automatic wait_idle(input string tag);
    int idle;
    idle = 0;
    for (int i = 0; i < C_BOUND && idle == 0; i++) begin
      tick();
      if (!busy && !busy8) idle = 1;
    end
    chk(tag, idle, 1);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic echo_pulse(input int gap, input int len);
    tick(gap);
    echo = 1'b1;
    tick(len);
    echo = 1'b0;
  endtask

  int s_trig, s_rv, s_to, s_rise, l_rv_cyc;

  initial begin
    tick(3);
    chk("rst_trig", trig, 0);
    chk("rst_busy", busy, 0);
    chk("rst_result", result, 0);
    chk("rst_rv", result_valid, 0);
    chk("rst_ovr", overrange, 0);
    chk("rst_to", timeout_err, 0);
    rst_n = 1'b1;
    tick(2);

    // 1: basic measurement
    s_trig = trig_hi; s_rv = rv_n; s_to = to_n;
    pulse_start();
    wait_evt(0, "t1_fall");
    echo_pulse(19, 100);
    wait_idle("t1_idle");
    chk("t1_trig_len", trig_hi - s_trig, 10);
    chk("t1_result", result, 100);
    chk("t1_rv_count", rv_n - s_rv, 1);
    chk("t1_ovr", overrange, 0);
    chk("t1_to_count", to_n - s_to, 0);

    // 2: timeout
    echo_wait = 16'd50;
    s_rv = rv_n; s_to = to_n;
    pulse_start();
    wait_evt(0, "t2_fall");
    wait_evt(3, "t2_to");
    chk("t2_to_delay", to_cyc - fall_cyc, 50);
    wait_idle("t2_idle");
    chk("t2_busy", busy, 0);
    chk("t2_result", result, 100);
    chk("t2_rv_count", rv_n - s_rv, 0);
    chk("t2_to_count", to_n - s_to, 1);

    // 3: saturation on the 8-bit instance
    echo_wait = 16'd200;
    holdoff = 16'd400;
    pulse_start();
    wait_evt(0, "t3_fall");
    tick(4);
    echo = 1'b1;
    tick(280);
    chk("t3_result8", result8, 255);
    chk("t3_ovr8", overrange8, 1);
    chk("t3_state8", 32'(dut8.r_state), 32'(ST_HOLDOFF));
    chk("t3_busy16", busy, 1);
    tick(20);
    echo = 1'b0;
    wait_idle("t3_idle");
    chk("t3_result16", result, 300);
    chk("t3_ovr16", overrange, 0);

    // 4: continuous mode re-trigger
    holdoff = 16'd30;
    continuous = 1'b1;
    s_rv = rv_n;
    pulse_start();
    wait_evt(0, "t4_fall1");
    echo_pulse(10, 40);
    wait_evt(2, "t4_rv1");
    l_rv_cyc = rv_cyc;
    chk("t4_result1", result, 40);
    wait_evt(1, "t4_rise2");
    chk("t4_retrig_gap", rise_cyc - l_rv_cyc, 31);
    continuous = 1'b0;
    wait_evt(0, "t4_fall2");
    echo_pulse(10, 40);
    wait_evt(2, "t4_rv2");
    chk("t4_result2", result, 40);
    wait_idle("t4_idle");
    chk("t4_rv_count", rv_n - s_rv, 2);

    // 5: reset mid-measurement, then start ignored while busy
    holdoff = 16'd5;
    s_rv = rv_n;
    pulse_start();
    wait_evt(0, "t5_fall");
    echo_pulse(5, 20);
    echo = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t5_trig", trig, 0);
    chk("t5_busy", busy, 0);
    chk("t5_result", result, 0);
    chk("t5_rv", result_valid, 0);
    tick();
    echo = 1'b0;
    rst_n = 1'b1;
    tick(3);
    chk("t5_no_partial", rv_n - s_rv, 0);
    s_rise = rises_n; s_rv = rv_n;
    pulse_start();
    wait_evt(0, "t5_fall2");
    pulse_start();
    echo_pulse(5, 30);
    wait_idle("t5_idle");
    tick(10);
    chk("t5_result2", result, 30);
    chk("t5_rise_count", rises_n - s_rise, 1);
    chk("t5_rv_count", rv_n - s_rv, 1);

    // 6: zero-length trigger and wait
    trig_len = 16'd0;
    echo_wait = 16'd0;
    s_trig = trig_hi;
    pulse_start();
    wait_evt(3, "t6_to");
    chk("t6_trig_len", trig_hi - s_trig, 1);
    chk("t6_to_delay", to_cyc - fall_cyc, 1);
    wait_idle("t6_idle");

    chk("rv_to_exclusive", both_n, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
